// File: rtl/approx_adder_err_accum.sv
// approx_adder_err_accum
// Streaming error-metric accumulator placed after an approximate W-bit adder.
// Each accepted sample carries both operands and the approximate sum. The block
// recomputes the exact sum and accumulates error count, sum of |error|, sum of
// error^2 and max |error| over a run of 2^L samples.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        clears results and starts a run (only honoured in IDLE/DONE)
//   in_valid     sample present
//   in_ready     sample accepted this cycle when in_valid is also high
//   in_a, in_b   operands (W bits)
//   in_approx    approximate adder result (W+1 bits)
//   busy         run or pipeline drain in progress
//   done         results final, held until next start or rst
//   sample_cnt   samples accepted this run
//   err_count    samples with nonzero error
//   sum_abs_err  sum of |approx - exact|
//   sum_sq_err   sum of (approx - exact)^2
//   max_abs_err  largest |approx - exact| seen
module approx_adder_err_accum #(
  parameter int W = 8,
  parameter int L = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_a,
  input  logic [W-1:0]           in_b,
  input  logic [W:0]             in_approx,
  output logic                   busy,
  output logic                   done,
  output logic [L:0]             sample_cnt,
  output logic [L:0]             err_count,
  output logic [W+L:0]           sum_abs_err,
  output logic [2*(W+1)+L-1:0]   sum_sq_err,
  output logic [W:0]             max_abs_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int SA_W = W + 1 + L;
  localparam int SQ_W = 2 * (W + 1) + L;
  localparam int P_W  = 2 * (W + 1);

  localparam logic [L:0] RUN_LEN = {1'b1, {L{1'b0}}};
  localparam logic [L:0] CNT_ONE = {{L{1'b0}}, 1'b1};

  // |approx - exact| with the exact sum zero-extended to W+1 bits; the
  // difference is carried in W+2 bits so its sign bit is never lost.
  function automatic logic [W:0] abs_err_f(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W:0]   approx);
    logic [W:0]   exact;
    logic [W+1:0] diff;
    logic [W+1:0] neg;
    exact = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, approx} - {1'b0, exact};
    neg   = (~diff) + {{(W+1){1'b0}}, 1'b1};
    if (diff[W+1]) begin
      abs_err_f = neg[W:0];
    end else begin
      abs_err_f = diff[W:0];
    end
  endfunction

  state_t            state_q, state_d;
  logic              drain_q, drain_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [L:0]        sample_cnt_q, sample_cnt_d;
  logic [L:0]        err_count_q, err_count_d;
  logic [SA_W-1:0]   sum_abs_q, sum_abs_d;
  logic [SQ_W-1:0]   sum_sq_q, sum_sq_d;
  logic [W:0]        max_abs_q, max_abs_d;
  logic              s1_valid_q, s1_valid_d;
  logic [W:0]        s1_abs_q, s1_abs_d;
  logic              s1_err_q, s1_err_d;

  logic              accept_s;
  logic              clear_s;
  logic [W:0]        abs_err_s;
  logic [P_W-1:0]    sq_s;

  // in_ready_q mirrors state==RUN, so acceptance never looks at in_valid
  // combinationally through the ready path.
  assign accept_s  = in_valid && in_ready_q;
  assign abs_err_s = abs_err_f(in_a, in_b, in_approx);
  assign sq_s      = {{(W+1){1'b0}}, s1_abs_q} * {{(W+1){1'b0}}, s1_abs_q};

  // Next-state logic for the run controller.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    clear_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          clear_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Leave RUN on the accept that completes the run.
        if (accept_s && ((sample_cnt_q + CNT_ONE) == RUN_LEN)) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        // Two cycles: one for the last stage-2 update, one to settle.
        if (drain_q) begin
          state_d = S_DONE;
          drain_d = 1'b0;
        end else begin
          drain_d = 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          clear_s = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        drain_d = 1'b0;
      end
    endcase
  end

  // Stage 1, stage 2 accumulators and registered status outputs.
  always_comb begin
    in_ready_d   = (state_d == S_RUN);
    busy_d       = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d       = (state_d == S_DONE);

    s1_valid_d   = accept_s;
    if (accept_s) begin
      s1_abs_d = abs_err_s;
      s1_err_d = (abs_err_s != {(W+1){1'b0}});
    end else begin
      s1_abs_d = {(W+1){1'b0}};
      s1_err_d = 1'b0;
    end

    sample_cnt_d = sample_cnt_q;
    err_count_d  = err_count_q;
    sum_abs_d    = sum_abs_q;
    sum_sq_d     = sum_sq_q;
    max_abs_d    = max_abs_q;

    if (clear_s) begin
      sample_cnt_d = {(L+1){1'b0}};
      err_count_d  = {(L+1){1'b0}};
      sum_abs_d    = {SA_W{1'b0}};
      sum_sq_d     = {SQ_W{1'b0}};
      max_abs_d    = {(W+1){1'b0}};
    end else begin
      if (accept_s) begin
        sample_cnt_d = sample_cnt_q + CNT_ONE;
      end else begin
        sample_cnt_d = sample_cnt_q;
      end
      if (s1_valid_q) begin
        if (s1_err_q) begin
          err_count_d = err_count_q + CNT_ONE;
        end else begin
          err_count_d = err_count_q;
        end
        sum_abs_d = sum_abs_q + {{L{1'b0}}, s1_abs_q};
        sum_sq_d  = sum_sq_q + {{L{1'b0}}, sq_s};
        if (s1_abs_q > max_abs_q) begin
          max_abs_d = s1_abs_q;
        end else begin
          max_abs_d = max_abs_q;
        end
      end else begin
        err_count_d = err_count_q;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      drain_q      <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sample_cnt_q <= {(L+1){1'b0}};
      err_count_q  <= {(L+1){1'b0}};
      sum_abs_q    <= {SA_W{1'b0}};
      sum_sq_q     <= {SQ_W{1'b0}};
      max_abs_q    <= {(W+1){1'b0}};
      s1_valid_q   <= 1'b0;
      s1_abs_q     <= {(W+1){1'b0}};
      s1_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      sample_cnt_q <= sample_cnt_d;
      err_count_q  <= err_count_d;
      sum_abs_q    <= sum_abs_d;
      sum_sq_q     <= sum_sq_d;
      max_abs_q    <= max_abs_d;
      s1_valid_q   <= s1_valid_d;
      s1_abs_q     <= s1_abs_d;
      s1_err_q     <= s1_err_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sample_cnt  = sample_cnt_q;
  assign err_count   = err_count_q;
  assign sum_abs_err = sum_abs_q;
  assign sum_sq_err  = sum_sq_q;
  assign max_abs_err = max_abs_q;

endmodule
